piso_serializer: RTL

Parallel-in/serial-out transmitter that takes a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clk, with a frame-valid and last-bit marker. It drives serial links whose far end is a chain of our reset-to-zero D flip-flops acting as a shift-in deserializer. Back-to-back words stream with no idle cycle between frames.

---
 rtl/piso_serializer.sv | 95 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word in, MSB-first bit stream out.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             sdata_o,
   output logic             svalid_o,
   output logic             slast_o,
   output logic             busy_o
);

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LOAD_COUNT = CW'(N - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         r_state;
   state_t         w_stateNext;
   logic [N-1:0]   r_shift;
   logic [N-1:0]   w_shiftNext;
   logic [N-1:0]   w_loadWord;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  w_countNext;
   logic           w_lastBit;
   logic           w_accept;

`ifdef PISO_SERIALIZER_PARITY_EN
   assign w_loadWord = {data_i, ^data_i};
`else
   assign w_loadWord = data_i;
`endif

   assign w_lastBit = (r_state == SHIFT) && (r_count == '0);
   assign ready_o   = (r_state == IDLE) || w_lastBit;
   assign w_accept  = valid_i && ready_o;

   assign sdata_o  = r_shift[N-1];
   assign svalid_o = (r_state == SHIFT);
   assign busy_o   = svalid_o;
   assign slast_o  = w_lastBit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_stateNext;
         r_shift <= w_shiftNext;
         r_count <= w_countNext;
      end
   end

   // The final shift of a frame leaves the register all-zero, so sdata_o idles low.
   always_comb begin
      w_stateNext = r_state;
      w_shiftNext = r_shift;
      w_countNext = r_count;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_shiftNext = w_loadWord;
               w_countNext = LOAD_COUNT;
               w_stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (w_accept) begin
               w_shiftNext = w_loadWord;
               w_countNext = LOAD_COUNT;
            end else if (r_count == '0) begin
               w_shiftNext = {r_shift[N-2:0], 1'b0};
               w_stateNext = IDLE;
            end else begin
               w_shiftNext = {r_shift[N-2:0], 1'b0};
               w_countNext = r_count - CW'(1);
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

endmodule
